// File: rtl/inst_encode_loader_if.sv
// Field-tuple input handshake plus instruction-memory write port of the loader.
// master: tuple producer / memory side (drives tuples and mem_ready).
// slave:  the loader (accepts tuples, issues memory writes).
interface inst_encode_loader_if #(
  parameter int ADDR_W = 10
);
  // Field-tuple handshake: transfer when valid && ready on a rising edge.
  logic              valid;
  logic              ready;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [31:0]       imm;
  logic              last;

  // Memory write handshake: write completes when mem_we && mem_ready.
  logic              mem_we;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output valid, opcode, rd, rs1, rs2, funct3, funct7, imm, last, mem_ready,
    input  ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  valid, opcode, rd, rs1, rs2, funct3, funct7, imm, last, mem_ready,
    output ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/inst_encode_loader.sv
// Encodes RV32 field tuples into 32-bit words and writes them to sequential memory words.
// Latency: tuple accepted in cycle N appears on the memory port in cycle N+1 when the buffer was empty.
// Backpressure: ready drops while the FIFO is full; mem_ready low holds the head word stable.
// Ports: clk_i, rst_ni (sync, active-low), start_i/base_addr_i session start,
//        bus (slave modport: tuple in, memory write out), done_o pulse, sticky err_o, count_o.

// Small synchronous FIFO with flush; head is read straight from the storage registers.
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   cnt_q;

  assign full     = (cnt_q == FULL_CNT);
  assign empty    = (cnt_q == '0);
  assign head_dat = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      // Storage is cleared too so the head reads zero after reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_dat;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

module inst_encode_loader #(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [ADDR_W-1:0]    base_addr_i,
  inst_encode_loader_if.slave  bus,
  output logic                 done_o,
  output logic                 err_o,
  output logic [ADDR_W-1:0]    count_o
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] count_q;
  logic              err_q;

  logic [31:0] enc_word;
  logic        illegal;
  logic        start_go, push, wr_done;
  logic        fifo_full, fifo_empty;
  logic [31:0] head_word;
  logic [31:0] imm;

  assign imm = bus.imm;

  // Field-to-word encoding; unknown opcodes become a NOP and raise err.
  always_comb begin
    enc_word = NOP_WORD;
    illegal  = 1'b0;
    case (bus.opcode)
      OP_R:
        enc_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
      OP_IMM, OP_LOAD, OP_JALR:
        enc_word = {imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
      OP_STORE:
        enc_word = {imm[11:5], bus.rs2, bus.rs1, bus.funct3, imm[4:0], bus.opcode};
      OP_BRANCH:
        enc_word = {imm[12], imm[10:5], bus.rs2, bus.rs1, bus.funct3, imm[4:1], imm[11], bus.opcode};
      OP_LUI, OP_AUIPC:
        enc_word = {imm[31:12], bus.rd, bus.opcode};
      OP_JAL:
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd, bus.opcode};
      default: begin
        enc_word = NOP_WORD;
        illegal  = 1'b1;
      end
    endcase
  end

  // ready only looks at the current fill level: a pop in the same cycle does not open a slot early.
  assign bus.ready  = (state_q == RUN) && !fifo_full;
  assign push       = bus.valid && bus.ready;
  assign bus.mem_we = ((state_q == RUN) || (state_q == DRAIN)) && !fifo_empty;
  assign wr_done    = bus.mem_we && bus.mem_ready;
  assign start_go   = start_i && (state_q == IDLE);

  sync_fifo #(
    .W     (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .flush    (start_go),
    .push     (push),
    .push_dat (enc_word),
    .pop      (wr_done),
    .head_dat (head_word),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (push && bus.last) state_d = DRAIN;
      // An empty FIFO implies mem_we is low, so no write is still outstanding.
      DRAIN:   if (fifo_empty) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_go) begin
        addr_q  <= base_addr_i & ~ADDR_W'(3);
        count_q <= '0;
        err_q   <= 1'b0;
      end else begin
        if (wr_done) begin
          addr_q  <= addr_q + ADDR_W'(4);
          count_q <= count_q + ADDR_W'(1);
        end
        if (push && illegal) err_q <= 1'b1;
      end
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = head_word;
  assign done_o        = (state_q == DONE);
  assign err_o         = err_q;
  assign count_o       = count_q;
endmodule

// File: tb/tb_inst_encode_loader.sv
module tb_inst_encode_loader;
  localparam int AW = 10;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic          done_o;
  logic          err_o;
  logic [AW-1:0] count_o;

  inst_encode_loader_if #(.ADDR_W(AW)) bus ();

  inst_encode_loader #(
    .ADDR_W     (AW),
    .FIFO_DEPTH (4)
  ) u_dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .bus         (bus),
    .done_o      (done_o),
    .err_o       (err_o),
    .count_o     (count_o)
  );

  always #5 clk_i = ~clk_i;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [31:0]   exp_q[$];
  logic [AW-1:0] exp_addr = '0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Scoreboard: every completed memory write must match the oldest expected word and the running address.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && bus.mem_we === 1'b1 && bus.mem_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_wr", 32'(bus.mem_we), 32'd0);
      end else begin
        check_eq("wr_data", bus.mem_wdata, exp_q.pop_front());
        check_eq("wr_addr", 32'(bus.mem_addr), 32'(exp_addr));
        exp_addr = exp_addr + AW'(4);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic start_session(input logic [AW-1:0] base);
    start_i     = 1'b1;
    base_addr_i = base;
    exp_addr    = base & ~AW'(3);
    tick(1);
    start_i     = 1'b0;
  endtask

  // Presents one tuple and waits (bounded) for it to be accepted; the expected word goes on the scoreboard.
  task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm, input logic last, input logic [31:0] exp);
    bit ok = 0;
    bus.opcode = op;  bus.rd = rd;   bus.rs1 = rs1; bus.rs2 = rs2;
    bus.funct3 = f3;  bus.funct7 = f7; bus.imm = imm; bus.last = last;
    bus.valid  = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk_i);
      if (bus.ready === 1'b1) begin
        ok = 1;
        exp_q.push_back(exp);
        @(posedge clk_i);
        #1;
      end
    end
    bus.valid = 1'b0;
    bus.last  = 1'b0;
    if (!ok) check_eq("accept_timeout", 32'(bus.ready), 32'd1);
  endtask

  task automatic wait_done(input int n_exp);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) seen = 1;
    end
    check_eq("done_seen", 32'(done_o), 32'd1);
    check_eq("count_at_done", 32'(count_o), 32'(n_exp));
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk_i);
    check_eq("done_one_cycle", 32'(done_o), 32'd0);
    tick(1);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_ready"}, 32'(bus.ready),  32'd0);
    check_eq({tag, "_we"},    32'(bus.mem_we), 32'd0);
    check_eq({tag, "_addr"},  32'(bus.mem_addr), 32'd0);
    check_eq({tag, "_wdata"}, bus.mem_wdata,   32'd0);
    check_eq({tag, "_done"},  32'(done_o),     32'd0);
    check_eq({tag, "_err"},   32'(err_o),      32'd0);
    check_eq({tag, "_count"}, 32'(count_o),    32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; base_addr_i = '0;
    bus.valid = 1'b0; bus.last = 1'b0; bus.mem_ready = 1'b0;
    bus.opcode = '0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0;
    bus.funct3 = '0; bus.funct7 = '0; bus.imm = '0;
    tick(3);
    check_reset_state("rst");
    rst_ni = 1'b1;
    tick(1);

    // add x3,x1,x2 as a single-tuple session; write must appear the cycle after acceptance.
    bus.mem_ready = 1'b1;
    start_session(10'h100);
    drive(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 32'h002081B3);
    @(negedge clk_i);
    check_eq("latency_we", 32'(bus.mem_we), 32'd1);
    wait_done(1);
    check_eq("err_after_r", 32'(err_o), 32'd0);

    // addi x1,x0,5 ; sw x2,8(x1)
    start_session(10'h100);
    drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 32'h00500093);
    drive(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b1, 32'h0020A423);
    wait_done(2);

    // lui x5 stalled by the memory; a start pulse mid-session must be ignored.
    bus.mem_ready = 1'b0;
    start_session(10'h100);
    drive(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b1, 32'h123452B7);
    start_i = 1'b1; base_addr_i = 10'h200;
    tick(1);
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check_eq("stall_we", 32'(bus.mem_we), 32'd1);
      check_eq("stall_wdata", bus.mem_wdata, 32'h123452B7);
    end
    check_eq("stall_count", 32'(count_o), 32'd0);
    bus.mem_ready = 1'b1;
    wait_done(1);

    // Fill the 4-deep buffer while stalled, then release and push a fifth tuple.
    bus.mem_ready = 1'b0;
    start_session(10'h040);
    drive(7'h63, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 32'hFFFFFFFC, 1'b0, 32'hFE209EE3);
    drive(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 1'b0, 32'h001000EF);
    drive(7'h17, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF000, 1'b0, 32'hFFFFF517);
    drive(7'h03, 5'd6, 5'd7, 5'd0, 3'd2, 7'd0, 32'hFFFFFFFF, 1'b0, 32'hFFF3A303);
    @(negedge clk_i);
    check_eq("full_ready", 32'(bus.ready), 32'd0);
    bus.mem_ready = 1'b1;
    drive(7'h67, 5'd0, 5'd1, 5'd0, 3'd0, 7'd0, 32'd0, 1'b1, 32'h00008067);
    wait_done(5);

    // Illegal opcode: NOP written, err sticky until the next start.
    start_session(10'h100);
    check_eq("err_pre", 32'(err_o), 32'd0);
    drive(7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 1'b1, 32'h00000013);
    check_eq("err_set", 32'(err_o), 32'd1);
    wait_done(1);
    check_eq("err_sticky", 32'(err_o), 32'd1);
    start_session(10'h100);
    check_eq("err_cleared", 32'(err_o), 32'd0);
    drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h00500093);
    wait_done(1);

    // Address wrap; low base bits are ignored.
    start_session(10'h3FF);
    drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 32'h00500093);
    drive(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b1, 32'h123452B7);
    wait_done(2);
    check_eq("wrap_next_addr", 32'(bus.mem_addr), 32'h004);

    // Reset in the middle of DRAIN aborts the session.
    bus.mem_ready = 1'b0;
    start_session(10'h010);
    drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 32'h00500093);
    drive(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b1, 32'h0020A423);
    @(negedge clk_i);
    check_eq("drain_we", 32'(bus.mem_we), 32'd1);
    rst_ni = 1'b0;
    tick(1);
    exp_q.delete();
    check_reset_state("midrst");
    rst_ni = 1'b1;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check_eq("post_rst_done", 32'(done_o), 32'd0);
      check_eq("post_rst_we", 32'(bus.mem_we), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
